mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_if.sv | 23 ++
 rtl/mem_access_stage.sv | 165 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and the data memory (slave).
interface mem_access_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_be;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage: lane-aligned loads/stores, jump-and-link write-back.
// Define MEM_MISALIGN_TRAP_EN to complete misaligned accesses as traps instead of force-aligning them.
//   state | meaning
//   IDLE  | accepting instructions, no memory transaction open
//   WAIT  | dm_req outstanding, waiting for dm_ack
module mem_access_stage #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_W    = 5,
  parameter int WB_W     = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop_debug,
  input  logic              in_valid,
  input  logic [1:0]        in_mem,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic              in_jl,
  input  logic [WB_W-1:0]   in_wb,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_regb,
  input  logic [REG_W-1:0]  in_wreg,
  output logic              busy,
  mem_access_stage_if.master dm,
  output logic              out_valid,
  output logic [WB_W-1:0]   out_wb,
  output logic [ADDR_W-1:0] out_alu,
  output logic [REG_W-1:0]  out_wreg,
  output logic [DATA_W-1:0] out_wd,
  output logic              out_misalign
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, nextState;

  logic [1:0]        effSize;
  logic [LANE_W-1:0] lane, alignMask, alignedLane;
  logic              misalign;
  logic [BE_W-1:0]   beBase, beVal;
  logic [DATA_W-1:0] wdataVal, shifted, loadVal, resultWd;
  logic              issue, finish, trapNow;

  // A dword request on a 32-bit path is carried as a word but always flagged misaligned.
  always_comb begin
    effSize     = (DATA_W == 32 && in_size == 2'b11) ? 2'b10 : in_size;
    lane        = in_alu[LANE_W-1:0];
    case (effSize)
      2'b00:   alignMask = '0;
      2'b01:   alignMask = LANE_W'(1);
      2'b10:   alignMask = LANE_W'(3);
      default: alignMask = LANE_W'(7);
    endcase
    misalign    = (in_size != effSize) || ((lane & alignMask) != '0);
    alignedLane = lane & ~alignMask;
    shifted     = dm.dm_rdata >> {alignedLane, 3'b000};
    case (effSize)
      2'b00: begin
        beBase   = BE_W'(1);
        wdataVal = {BE_W{in_regb[7:0]}};
        loadVal  = in_unsigned ? DATA_W'(shifted[7:0]) : DATA_W'($signed(shifted[7:0]));
      end
      2'b01: begin
        beBase   = BE_W'(3);
        wdataVal = {(BE_W/2){in_regb[15:0]}};
        loadVal  = in_unsigned ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
      end
      2'b10: begin
        beBase   = BE_W'(15);
        wdataVal = {(DATA_W/32){in_regb[31:0]}};
        loadVal  = in_unsigned ? DATA_W'(shifted[31:0]) : DATA_W'($signed(shifted[31:0]));
      end
      default: begin
        beBase   = BE_W'(8'hFF);
        wdataVal = in_regb;
        loadVal  = shifted;
      end
    endcase
    beVal    = beBase << alignedLane;
    resultWd = in_jl ? DATA_W'(in_pc) : (in_mem[1] ? loadVal : DATA_W'(in_alu));
  end

  always_comb begin
    nextState = state;
    issue     = 1'b0;
    finish    = 1'b0;
    trapNow   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_mem != 2'b00 && TRAP && misalign) begin
            finish  = 1'b1;
            trapNow = 1'b1;
          end else if (in_mem != 2'b00) begin
            issue     = 1'b1;
            nextState = WAIT;
          end else begin
            finish = 1'b1;
          end
        end
      end
      WAIT: begin
        if (dm.dm_ack) begin
          finish    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign busy = (state == WAIT);

  always_ff @(posedge clk) begin
    if (!rst)            state <= IDLE;
    else if (!stop_debug) state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dm.dm_req    <= 1'b0;
      dm.dm_we     <= 1'b0;
      dm.dm_addr   <= '0;
      dm.dm_wdata  <= '0;
      dm.dm_be     <= '0;
      out_valid    <= 1'b0;
      out_wb       <= '0;
      out_alu      <= '0;
      out_wreg     <= '0;
      out_wd       <= '0;
      out_misalign <= 1'b0;
    end else if (!stop_debug) begin
      out_valid <= finish;
      if (issue) begin
        dm.dm_req   <= 1'b1;
        dm.dm_we    <= in_mem[0];
        dm.dm_addr  <= {in_alu[ADDR_W-1:LANE_W], LANE_W'(0)};
        dm.dm_wdata <= wdataVal;
        dm.dm_be    <= beVal;
      end else if (finish && state == WAIT) begin
        dm.dm_req <= 1'b0;
        dm.dm_we  <= 1'b0;
        dm.dm_be  <= '0;
      end
      if (finish) begin
        out_wb       <= trapNow ? '0 : in_wb;
        out_alu      <= in_alu;
        out_wreg     <= in_jl ? REG_W'(LINK_REG) : in_wreg;
        out_wd       <= resultWd;
        out_misalign <= trapNow;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (32-bit data path, either trap build).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst, stop_debug, in_valid, in_unsigned, in_jl;
  logic [1:0]  in_mem, in_size;
  logic [4:0]  in_wb, in_wreg;
  logic [31:0] in_pc, in_alu, in_regb;
  logic        busy, out_valid, out_misalign;
  logic [4:0]  out_wb, out_wreg;
  logic [31:0] out_alu, out_wd;

  int checks = 0;
  int errors = 0;

  mem_access_stage_if #(.ADDR_W(32), .DATA_W(32)) dmIf ();

  mem_access_stage #(.DATA_W(32), .ADDR_W(32), .REG_W(5), .WB_W(5), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .stop_debug(stop_debug), .in_valid(in_valid),
    .in_mem(in_mem), .in_size(in_size), .in_unsigned(in_unsigned), .in_jl(in_jl),
    .in_wb(in_wb), .in_pc(in_pc), .in_alu(in_alu), .in_regb(in_regb), .in_wreg(in_wreg),
    .busy(busy), .dm(dmIf.master), .out_valid(out_valid), .out_wb(out_wb),
    .out_alu(out_alu), .out_wreg(out_wreg), .out_wd(out_wd), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    in_valid = 0; in_mem = 0; in_size = 0; in_unsigned = 0; in_jl = 0;
    in_wb = 0; in_pc = 0; in_alu = 0; in_regb = 0; in_wreg = 0;
    dmIf.dm_ack = 0; dmIf.dm_rdata = 32'hDEAD_DEAD;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, dmIf.dm_req, dmIf.dm_we, dmIf.dm_be, out_valid, out_misalign} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl got busy=%0b req=%0b we=%0b be=%h valid=%0b mis=%0b exp all 0",
               busy, dmIf.dm_req, dmIf.dm_we, dmIf.dm_be, out_valid, out_misalign);
    end
    checks++;
    if ({out_wb, out_alu, out_wreg, out_wd, dmIf.dm_addr, dmIf.dm_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data got wb=%h alu=%h wreg=%h wd=%h addr=%h wdata=%h exp all 0",
               out_wb, out_alu, out_wreg, out_wd, dmIf.dm_addr, dmIf.dm_wdata);
    end
    rst = 1;
  endtask

  task automatic test_alu();
    in_valid = 1; in_alu = 32'h1234; in_wreg = 7; in_wb = 5'h11;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL alu_busy_comb got %0b exp 0", busy); end
    @(negedge clk);
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_wd !== 32'h1234 || out_wreg !== 5'd7 || out_wb !== 5'h11 || busy !== 1'b0)
    begin
      errors++;
      $display("FAIL alu_result got valid=%0b wd=%h wreg=%0d wb=%h busy=%0b exp 1 00001234 7 11 0",
               out_valid, out_wd, out_wreg, out_wb, busy);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_pulse got %0b exp 0", out_valid); end
    clear_inputs();
  endtask

  task automatic test_jal();
    in_valid = 1; in_jl = 1; in_pc = 32'h400; in_wreg = 3; in_alu = 32'h9999;
    @(negedge clk);
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_wreg !== 5'd31 || out_wd !== 32'h400) begin
      errors++;
      $display("FAIL jal got valid=%0b wreg=%0d wd=%h exp 1 31 00000400", out_valid, out_wreg, out_wd);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    in_valid = 1; in_alu = 32'h10; in_wreg = 1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_wd !== 32'h10 || out_wreg !== 5'd1) begin
      errors++; $display("FAIL b2b_first got valid=%0b wd=%h wreg=%0d exp 1 10 1", out_valid, out_wd, out_wreg);
    end
    in_alu = 32'h20; in_wreg = 2;
    @(negedge clk);
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_wd !== 32'h20 || out_wreg !== 5'd2) begin
      errors++; $display("FAIL b2b_second got valid=%0b wd=%h wreg=%0d exp 1 20 2", out_valid, out_wd, out_wreg);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_mem_access(input string name, input logic [1:0] mem, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] regb,
                                 input logic [31:0] rdata, input int waitCycles, input logic [3:0] expBe,
                                 input logic [31:0] expWdata, input logic [31:0] expAddr,
                                 input logic [31:0] expWd);
    int busyCnt = 0;
    in_valid = 1; in_mem = mem; in_size = size; in_unsigned = uns; in_alu = addr;
    in_regb = regb; in_wreg = 5'd9; in_wb = 5'h0A;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s_issue got valid=%0b busy=%0b exp 0 1", name, out_valid, busy);
    end
    for (int i = 0; i <= waitCycles; i++) begin
      if (i > 0) @(negedge clk);
      if (busy === 1'b1) busyCnt++;
      checks++;
      if (dmIf.dm_req !== 1'b1 || dmIf.dm_we !== mem[0] || dmIf.dm_be !== expBe ||
          dmIf.dm_addr !== expAddr || (mem[0] && dmIf.dm_wdata !== expWdata)) begin
        errors++;
        $display("FAIL %s_bus cyc%0d got req=%0b we=%0b be=%h addr=%h wdata=%h exp 1 %0b %h %h %h",
                 name, i, dmIf.dm_req, dmIf.dm_we, dmIf.dm_be, dmIf.dm_addr, dmIf.dm_wdata,
                 mem[0], expBe, expAddr, expWdata);
      end
    end
    dmIf.dm_ack = 1; dmIf.dm_rdata = rdata;
    @(negedge clk);
    clear_inputs();
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || dmIf.dm_req !== 1'b0 || out_wd !== expWd ||
        out_alu !== addr || out_wreg !== 5'd9 || out_wb !== 5'h0A) begin
      errors++;
      $display("FAIL %s_done got valid=%0b busy=%0b req=%0b wd=%h alu=%h wreg=%0d wb=%h exp 1 0 0 %h %h 9 0a",
               name, out_valid, busy, dmIf.dm_req, out_wd, out_alu, out_wreg, out_wb, expWd, addr);
    end
    checks++;
    if (busyCnt != waitCycles + 1) begin
      errors++; $display("FAIL %s_busy_cycles got %0d exp %0d", name, busyCnt, waitCycles + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    in_valid = 1; in_mem = 2'b10; in_size = 2'b10; in_alu = 32'h101; in_wb = 5'h1F; in_wreg = 4;
    @(negedge clk);
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_misalign !== 1'b1 || out_wb !== 5'h0 || dmIf.dm_req !== 1'b0 || busy !== 1'b0)
    begin
      errors++;
      $display("FAIL trap_lw got valid=%0b mis=%0b wb=%h req=%0b busy=%0b exp 1 1 00 0 0",
               out_valid, out_misalign, out_wb, dmIf.dm_req, busy);
    end
    clear_inputs();
    @(negedge clk);
`else
    test_mem_access("lw_mis", 2'b10, 2'b10, 1'b0, 32'h101, 32'h0, 32'h1122_3344, 1,
                    4'hF, 32'h0, 32'h100, 32'h1122_3344);
    checks++;
    if (out_misalign !== 1'b0) begin errors++; $display("FAIL lw_mis_flag got %0b exp 0", out_misalign); end
`endif
  endtask

  task automatic test_stop_debug();
    stop_debug = 1; in_valid = 1; in_alu = 32'h55;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL freeze_idle got valid=%0b exp 0", out_valid); end
    stop_debug = 0;
    @(negedge clk);
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_wd !== 32'h55) begin
      errors++; $display("FAIL unfreeze_idle got valid=%0b wd=%h exp 1 55", out_valid, out_wd);
    end
    clear_inputs();
    in_valid = 1; in_mem = 2'b10; in_size = 2'b10; in_alu = 32'h300;
    @(negedge clk);
    stop_debug = 1; dmIf.dm_ack = 1; dmIf.dm_rdata = 32'h0000_0055;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || dmIf.dm_req !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL freeze_wait got busy=%0b req=%0b valid=%0b exp 1 1 0", busy, dmIf.dm_req, out_valid);
      end
    end
    stop_debug = 0; dmIf.dm_ack = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL freeze_ack_ignored got busy=%0b valid=%0b exp 1 0", busy, out_valid);
    end
    dmIf.dm_ack = 1; dmIf.dm_rdata = 32'h0000_0077;
    @(negedge clk);
    clear_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_wd !== 32'h77 || busy !== 1'b0) begin
      errors++; $display("FAIL freeze_done got valid=%0b wd=%h busy=%0b exp 1 77 0", out_valid, out_wd, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    in_valid = 1; in_mem = 2'b10; in_size = 2'b10; in_alu = 32'h400;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstwait_enter got busy=%0b exp 1", busy); end
    rst = 0; stop_debug = 1; in_valid = 0;
    @(negedge clk);
    rst = 1; stop_debug = 0; dmIf.dm_ack = 1; dmIf.dm_rdata = 32'h1;
    checks++;
    if (busy !== 1'b0 || dmIf.dm_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rstwait_abort got busy=%0b req=%0b valid=%0b exp 0 0 0", busy, dmIf.dm_req, out_valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || dmIf.dm_req !== 1'b0) begin
      errors++; $display("FAIL rstwait_late_ack got busy=%0b valid=%0b req=%0b exp 0 0 0", busy, out_valid, dmIf.dm_req);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    stop_debug = 0;
    clear_inputs();
    test_reset();
    @(negedge clk);
    test_alu();
    test_jal();
    test_back_to_back();
    test_mem_access("lb",  2'b10, 2'b00, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 3, 4'h8, 32'h0, 32'h100, 32'hFFFF_FF80);
    test_mem_access("lbu", 2'b10, 2'b00, 1'b1, 32'h102, 32'h0, 32'h00AB_0000, 0, 4'h4, 32'h0, 32'h100, 32'h0000_00AB);
    test_mem_access("lh",  2'b10, 2'b01, 1'b0, 32'h102, 32'h0, 32'h8001_0000, 1, 4'hC, 32'h0, 32'h100, 32'hFFFF_8001);
    test_mem_access("lhu", 2'b10, 2'b01, 1'b1, 32'h200, 32'h0, 32'h1234_F00F, 0, 4'h3, 32'h0, 32'h200, 32'h0000_F00F);
    test_mem_access("lw",  2'b10, 2'b10, 1'b0, 32'h204, 32'h0, 32'hCAFE_BABE, 2, 4'hF, 32'h0, 32'h204, 32'hCAFE_BABE);
    test_mem_access("sh",  2'b01, 2'b01, 1'b0, 32'h102, 32'h9999_ABCD, 32'h0, 2, 4'hC, 32'hABCD_ABCD, 32'h100, 32'h102);
    test_mem_access("sb",  2'b01, 2'b00, 1'b0, 32'h101, 32'h1234_565A, 32'h0, 0, 4'h2, 32'h5A5A_5A5A, 32'h100, 32'h101);
    test_mem_access("sw",  2'b01, 2'b10, 1'b0, 32'h200, 32'hDEAD_BEEF, 32'h0, 1, 4'hF, 32'hDEAD_BEEF, 32'h200, 32'h200);
    test_misalign();
    test_stop_debug();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
